// File: rtl/rv32_mod_instruction_fetch.sv
`timescale 1ns/1ps
// Fetch and parcel alignment: fetches aligned words, buffers 16-bit parcels, issues whole RV32C/RV32 instructions.
// Latency: imem_ack in cycle N -> instr_valid in cycle N+1; first request in the cycle after reset release.
// Backpressure: outputs hold while instr_valid && !instr_ready; new fetches issue only when <= 1 parcel remains.
module rv32_mod_instruction_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        instr_compressed
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2
   } fetch_state_t;

   localparam logic [31:0] RESET_WORD = {RESET_PC[31:2], 2'b00};

   fetch_state_t     state_q, state_d;

   // Parcel buffer, entry 0 is the oldest halfword and sits at pc_q.
   logic [2:0][15:0] hw_q, hw_s, hw_d;
   logic [1:0]       count_q, count_s, count_d;

   logic [31:0]      pc_q, pc_d;
   logic [31:0]      fetch_addr_q, fetch_addr_d;
   logic [31:0]      req_addr_q, req_addr_d;
   logic             skip_lo_q, skip_lo_d;

   logic             hw0_is_c;
   logic             have_instr;
   logic             consume;
   logic             take_two;
   logic             append;
   logic [15:0]      rdata_lo;
   logic [15:0]      rdata_hi;

   // Instruction boundary detection on the oldest parcel; anything with
   // low bits 11 is handled as a 32-bit instruction.
   assign hw0_is_c   = (hw_q[0][1:0] != 2'b11);
   assign have_instr = ((count_q >= 2'd1) && hw0_is_c) ||
                       ((count_q >= 2'd2) && !hw0_is_c);
   assign consume    = have_instr && instr_ready;
   assign take_two   = !hw0_is_c;

   // Only a live (non-stale, non-flushed) response is written into the buffer.
   assign append     = (state_q == S_WAIT) && imem_ack && !redirect;
   assign rdata_lo   = imem_rdata[15:0];
   assign rdata_hi   = imem_rdata[31:16];

   assign imem_req         = (state_q != S_IDLE);
   assign imem_addr        = req_addr_q;
   assign instr_valid      = have_instr;
   assign instr_pc         = pc_q;
   assign instr_compressed = have_instr && hw0_is_c;

   // Present the instruction at the head of the buffer, zero when none is whole.
   always_comb begin
      instr = 32'h0;
      if (have_instr) begin
         if (hw0_is_c) begin
            instr = {16'h0, hw_q[0]};
         end else begin
            instr = {hw_q[1], hw_q[0]};
         end
      end
   end

   // Shift out the parcels taken by the decoder this cycle.
   always_comb begin
      hw_s    = hw_q;
      count_s = count_q;
      if (consume) begin
         if (take_two) begin
            hw_s[0] = hw_q[2];
            hw_s[1] = 16'h0;
            hw_s[2] = 16'h0;
            count_s = count_q - 2'd2;
         end else begin
            hw_s[0] = hw_q[1];
            hw_s[1] = hw_q[2];
            hw_s[2] = 16'h0;
            count_s = count_q - 2'd1;
         end
      end
   end

   // Append fetched parcels behind what is left, then let a redirect flush everything.
   always_comb begin
      hw_d         = hw_s;
      count_d      = count_s;
      pc_d         = pc_q;
      fetch_addr_d = fetch_addr_q;
      skip_lo_d    = skip_lo_q;

      if (consume) begin
         pc_d = pc_q + (take_two ? 32'd4 : 32'd2);
      end

      if (append) begin
         fetch_addr_d = fetch_addr_q + 32'd4;
         skip_lo_d    = 1'b0;
         if (skip_lo_q) begin
            // Redirect landed on the upper halfword: only that half is useful.
            case (count_s)
               2'd0:    hw_d[0] = rdata_hi;
               2'd1:    hw_d[1] = rdata_hi;
               default: hw_d[2] = rdata_hi;
            endcase
            count_d = count_s + 2'd1;
         end else begin
            // Requests are only made with <= 1 parcel left, so two always fit.
            case (count_s)
               2'd0: begin
                  hw_d[0] = rdata_lo;
                  hw_d[1] = rdata_hi;
               end
               default: begin
                  hw_d[1] = rdata_lo;
                  hw_d[2] = rdata_hi;
               end
            endcase
            count_d = count_s + 2'd2;
         end
      end

      if (redirect) begin
         hw_d         = '0;
         count_d      = 2'd0;
         pc_d         = {redirect_pc[31:1], 1'b0};
         fetch_addr_d = {redirect_pc[31:2], 2'b00};
         skip_lo_d    = redirect_pc[1];
      end
   end

   // Fetch FSM next state; the request address is latched only when a new request starts.
   always_comb begin
      state_d    = state_q;
      req_addr_d = req_addr_q;

      case (state_q)
         S_IDLE: begin
            if (redirect || (count_s <= 2'd1)) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (redirect) begin
               // With the ack in hand the old request is closed and the new one
               // can start at once; otherwise the stale response must be absorbed.
               state_d = imem_ack ? S_WAIT : S_DROP;
            end else if (imem_ack) begin
               state_d = S_IDLE;
            end
         end
         S_DROP: begin
            if (imem_ack) begin
               state_d = S_WAIT;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A new request begins on entry to WAIT or on WAIT->WAIT through an ack;
      // in DROP the old address must stay on the bus until its ack.
      if ((state_d == S_WAIT) && ((state_q != S_WAIT) || imem_ack)) begin
         req_addr_d = fetch_addr_d;
      end
   end

   // State register with synchronous reset; an ack during reset is ignored.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         hw_q         <= '0;
         count_q      <= 2'd0;
         pc_q         <= RESET_PC;
         fetch_addr_q <= RESET_WORD;
         req_addr_q   <= RESET_WORD;
         skip_lo_q    <= RESET_PC[1];
      end else begin
         state_q      <= state_d;
         hw_q         <= hw_d;
         count_q      <= count_d;
         pc_q         <= pc_d;
         fetch_addr_q <= fetch_addr_d;
         req_addr_q   <= req_addr_d;
         skip_lo_q    <= skip_lo_d;
      end
   end

endmodule

// File: tb/tb_rv32_mod_instruction_fetch.sv
`timescale 1ns/1ps
// Bench for the fetch/align stage: memory responder with programmable wait states,
// a program-order reference model checking every handshake, and directed scenarios.
// Inputs are driven after the falling edge; outputs are sampled away from the rising edge.
module tb_rv32_mod_instruction_fetch;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_compressed;

   logic [31:0] mem [0:255];
   int          vec_cnt = 0;
   int          err_cnt = 0;
   int          hs_cnt  = 0;
   int unsigned wait_lo = 0;
   int unsigned wait_hi = 0;
   logic [31:0] model_pc;

   always #5 clk = ~clk;

   rv32_mod_instruction_fetch #(.RESET_PC(RESET_PC)) dut (
      .clk              (clk),
      .rst              (rst),
      .imem_req         (imem_req),
      .imem_addr        (imem_addr),
      .imem_ack         (imem_ack),
      .imem_rdata       (imem_rdata),
      .redirect         (redirect),
      .redirect_pc      (redirect_pc),
      .instr_valid      (instr_valid),
      .instr_ready      (instr_ready),
      .instr            (instr),
      .instr_pc         (instr_pc),
      .instr_compressed (instr_compressed)
   );

   // Halfword of the program image at byte address a (1 KiB image, wraps).
   function automatic logic [15:0] mem_hw(input logic [31:0] a);
      logic [31:0] w;
      w = mem[a[9:2]];
      return a[1] ? w[31:16] : w[15:0];
   endfunction

   // Memory side: random or fixed wait states per request, address stability checked.
   initial begin : mem_side
      int unsigned wcnt;
      logic        in_req;
      logic [31:0] held_addr;
      imem_ack   = 1'b0;
      imem_rdata = 32'h0;
      in_req     = 1'b0;
      wcnt       = 0;
      held_addr  = 32'h0;
      forever begin
         @(negedge clk);
         if (rst || (imem_req !== 1'b1)) begin
            imem_ack = 1'b0;
            in_req   = 1'b0;
         end else begin
            if (!in_req || imem_ack) begin
               in_req    = 1'b1;
               held_addr = imem_addr;
               wcnt      = $urandom_range(wait_hi, wait_lo);
               vec_cnt++;
               if (imem_addr[1:0] !== 2'b00) begin
                  err_cnt++;
                  $display("FAIL imem_addr_align: got %h, required low bits 00", imem_addr);
               end
            end else begin
               vec_cnt++;
               if (imem_addr !== held_addr) begin
                  err_cnt++;
                  $display("FAIL imem_addr_stable: got %h, required %h", imem_addr, held_addr);
               end
            end
            if (wcnt == 0) begin
               imem_ack   = 1'b1;
               imem_rdata = mem[imem_addr[9:2]];
            end else begin
               wcnt--;
               imem_ack   = 1'b0;
               imem_rdata = $urandom();
            end
         end
      end
   end

   // Reference model: walks the program image in order from the last reset/redirect
   // target and checks every accepted instruction; also checks hold under stall.
   initial begin : scoreboard
      logic        prev_hold;
      logic [64:0] prev_out;
      logic [64:0] got_out;
      logic [64:0] exp_out;
      logic [15:0] lo;
      logic [15:0] hi;
      logic [31:0] len;
      prev_hold = 1'b0;
      prev_out  = '0;
      model_pc  = RESET_PC;
      forever begin
         @(negedge clk);
         #2;
         got_out = {instr, instr_pc, instr_compressed};
         if (rst) begin
            model_pc  = RESET_PC;
            prev_hold = 1'b0;
         end else begin
            if (prev_hold) begin
               vec_cnt++;
               if (instr_valid !== 1'b1 || got_out !== prev_out) begin
                  err_cnt++;
                  $display("FAIL hold_stable: got valid=%b out=%h, required valid=1 out=%h",
                           instr_valid, got_out, prev_out);
               end
            end
            if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
               lo = mem_hw(model_pc);
               if (lo[1:0] != 2'b11) begin
                  exp_out = {16'h0, lo, model_pc, 1'b1};
                  len     = 32'd2;
               end else begin
                  hi      = mem_hw(model_pc + 32'd2);
                  exp_out = {hi, lo, model_pc, 1'b0};
                  len     = 32'd4;
               end
               vec_cnt++;
               hs_cnt++;
               if (got_out !== exp_out) begin
                  err_cnt++;
                  $display("FAIL handshake: got instr=%h pc=%h c=%b, required instr=%h pc=%h c=%b",
                           got_out[64:33], got_out[32:1], got_out[0],
                           exp_out[64:33], exp_out[32:1], exp_out[0]);
               end
               model_pc = model_pc + len;
            end
            prev_hold = (instr_valid === 1'b1) && (instr_ready !== 1'b1) && (redirect !== 1'b1);
            prev_out  = got_out;
            if (redirect === 1'b1) model_pc = {redirect_pc[31:1], 1'b0};
         end
      end
   end

   // Leaves the caller on the falling edge of cycle 0 (first cycle with rst low).
   task automatic do_reset;
      @(negedge clk);
      rst         = 1'b1;
      instr_ready = 1'b0;
      redirect    = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic step;
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset;
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[0]  = 32'h00A00093;
      wait_lo = 0;
      wait_hi = 0;
      do_reset;
      #1;
      vec_cnt++;
      if ({imem_req, instr_valid, instr, instr_pc, instr_compressed} !== {2'b00, 32'h0, RESET_PC, 1'b0}) begin
         err_cnt++;
         $display("FAIL reset_outputs: got req=%b vld=%b instr=%h pc=%h c=%b, required 0 0 0 %h 0",
                  imem_req, instr_valid, instr, instr_pc, instr_compressed, RESET_PC);
      end
      step;  // cycle 1
      vec_cnt++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
         err_cnt++;
         $display("FAIL reset_first_req: got req=%b addr=%h, required 1 00000000", imem_req, imem_addr);
      end
      step;  // cycle 2
      vec_cnt++;
      if ({instr_valid, instr, instr_pc, instr_compressed} !== {1'b1, 32'h00A00093, 32'h0, 1'b0}) begin
         err_cnt++;
         $display("FAIL reset_first_instr: got vld=%b instr=%h pc=%h c=%b, required 1 00a00093 0 0",
                  instr_valid, instr, instr_pc, instr_compressed);
      end
      instr_ready = 1'b1;
      step;
      instr_ready = 1'b0;
   endtask

   task automatic test_two_compressed;
      mem[0] = 32'h4505_4501;
      mem[1] = 32'h0001_0001;
      do_reset;
      #1;
      instr_ready = 1'b1;
      step;
      step;  // cycle 2
      vec_cnt++;
      if ({instr_valid, instr, instr_pc, instr_compressed} !== {1'b1, 32'h4501, 32'h0, 1'b1}) begin
         err_cnt++;
         $display("FAIL c_first: got vld=%b instr=%h pc=%h c=%b, required 1 00004501 0 1",
                  instr_valid, instr, instr_pc, instr_compressed);
      end
      step;  // cycle 3
      vec_cnt++;
      if ({instr_valid, instr, instr_pc, instr_compressed} !== {1'b1, 32'h4505, 32'h2, 1'b1}) begin
         err_cnt++;
         $display("FAIL c_second: got vld=%b instr=%h pc=%h c=%b, required 1 00004505 2 1",
                  instr_valid, instr, instr_pc, instr_compressed);
      end
      instr_ready = 1'b0;
   endtask

   task automatic test_misaligned;
      mem[0] = 32'h0093_4501;
      mem[1] = 32'h0000_00A0;
      do_reset;
      #1;
      instr_ready = 1'b1;
      step;
      step;  // cycle 2: c.li
      vec_cnt++;
      if ({instr_valid, instr, instr_pc} !== {1'b1, 32'h4501, 32'h0}) begin
         err_cnt++;
         $display("FAIL mis_cli: got vld=%b instr=%h pc=%h, required 1 00004501 0", instr_valid, instr, instr_pc);
      end
      step;  // cycle 3: upper half only, second word being fetched
      vec_cnt++;
      if ({instr_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h4}) begin
         err_cnt++;
         $display("FAIL mis_wait: got vld=%b req=%b addr=%h, required 0 1 00000004", instr_valid, imem_req, imem_addr);
      end
      step;  // cycle 4
      vec_cnt++;
      if ({instr_valid, instr, instr_pc, instr_compressed} !== {1'b1, 32'h00A00093, 32'h2, 1'b0}) begin
         err_cnt++;
         $display("FAIL mis_32: got vld=%b instr=%h pc=%h c=%b, required 1 00a00093 2 0",
                  instr_valid, instr, instr_pc, instr_compressed);
      end
      step;
      instr_ready = 1'b0;
   endtask

   task automatic test_redirect_drop;
      int n;
      mem[0]  = 32'h4505_4501;
      mem[64] = 32'h4515_4501;
      wait_lo = 3;
      wait_hi = 3;
      do_reset;
      #1;
      instr_ready = 1'b1;
      step;
      step;  // cycle 2: request to 0 still open
      redirect    = 1'b1;
      redirect_pc = 32'h102;
      step;  // cycle 3: DROP, stale address held
      redirect = 1'b0;
      vec_cnt++;
      if ({instr_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h0}) begin
         err_cnt++;
         $display("FAIL drop_hold: got vld=%b req=%b addr=%h, required 0 1 00000000", instr_valid, imem_req, imem_addr);
      end
      step;  // cycle 4: stale ack
      step;  // cycle 5
      vec_cnt++;
      if ({imem_req, imem_addr} !== {1'b1, 32'h100}) begin
         err_cnt++;
         $display("FAIL drop_refetch: got req=%b addr=%h, required 1 00000100", imem_req, imem_addr);
      end
      n = 0;
      while (instr_valid !== 1'b1 && n < 30) begin
         step;
         n++;
      end
      vec_cnt++;
      if ({instr_valid, instr, instr_pc, instr_compressed} !== {1'b1, 32'h4515, 32'h102, 1'b1}) begin
         err_cnt++;
         $display("FAIL drop_first_instr: got vld=%b instr=%h pc=%h c=%b, required 1 00004515 102 1",
                  instr_valid, instr, instr_pc, instr_compressed);
      end
      step;
      instr_ready = 1'b0;
      wait_lo     = 0;
      wait_hi     = 0;
   endtask

   task automatic test_stall;
      mem[0] = 32'h4505_4501;
      mem[1] = 32'h0005_0009;
      do_reset;
      step;
      step;  // cycle 2: two parcels buffered
      for (int i = 0; i < 5; i++) begin
         vec_cnt++;
         if ({instr_valid, instr, instr_pc, imem_req} !== {1'b1, 32'h4501, 32'h0, 1'b0}) begin
            err_cnt++;
            $display("FAIL stall_hold: got vld=%b instr=%h pc=%h req=%b, required 1 00004501 0 0",
                     instr_valid, instr, instr_pc, imem_req);
         end
         if (i < 4) step;
      end
      instr_ready = 1'b1;
      step;
      vec_cnt++;
      if ({instr_valid, instr, instr_pc} !== {1'b1, 32'h4505, 32'h2}) begin
         err_cnt++;
         $display("FAIL stall_release: got vld=%b instr=%h pc=%h, required 1 00004505 2", instr_valid, instr, instr_pc);
      end
      repeat (4) step;
      instr_ready = 1'b0;
   endtask

   task automatic test_redirect_ack;
      int n;
      mem[0]   = 32'h0001_0001;
      mem[128] = 32'h4511_4509;
      wait_lo  = 2;
      wait_hi  = 2;
      do_reset;
      #1;
      instr_ready = 1'b1;
      step;
      step;
      step;  // cycle 3: ack of the old request arrives now
      redirect    = 1'b1;
      redirect_pc = 32'h201;
      step;  // cycle 4
      redirect = 1'b0;
      vec_cnt++;
      if ({instr_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h200}) begin
         err_cnt++;
         $display("FAIL rdack_req: got vld=%b req=%b addr=%h, required 0 1 00000200", instr_valid, imem_req, imem_addr);
      end
      n = 0;
      while (instr_valid !== 1'b1 && n < 30) begin
         step;
         n++;
      end
      vec_cnt++;
      if ({instr_valid, instr, instr_pc} !== {1'b1, 32'h4509, 32'h200}) begin
         err_cnt++;
         $display("FAIL rdack_instr: got vld=%b instr=%h pc=%h, required 1 00004509 200", instr_valid, instr, instr_pc);
      end
      step;
      instr_ready = 1'b0;
      wait_lo     = 0;
      wait_hi     = 0;
   endtask

   task automatic test_redirect_handshake;
      int n;
      int h0;
      mem[0]   = 32'h4505_4501;
      mem[192] = 32'h4519_451D;
      do_reset;
      #1;
      instr_ready = 1'b1;
      step;
      step;  // cycle 2: 0x4501 is accepted while the redirect flushes
      h0          = hs_cnt;
      redirect    = 1'b1;
      redirect_pc = 32'h300;
      step;
      redirect = 1'b0;
      vec_cnt++;
      if (hs_cnt - h0 !== 1) begin
         err_cnt++;
         $display("FAIL rdhs_count: got %0d handshakes, required 1", hs_cnt - h0);
      end
      vec_cnt++;
      if ({instr_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h300}) begin
         err_cnt++;
         $display("FAIL rdhs_req: got vld=%b req=%b addr=%h, required 0 1 00000300", instr_valid, imem_req, imem_addr);
      end
      n = 0;
      while (instr_valid !== 1'b1 && n < 30) begin
         step;
         n++;
      end
      vec_cnt++;
      if ({instr_valid, instr, instr_pc} !== {1'b1, 32'h451D, 32'h300}) begin
         err_cnt++;
         $display("FAIL rdhs_instr: got vld=%b instr=%h pc=%h, required 1 0000451d 300", instr_valid, instr, instr_pc);
      end
      step;
      instr_ready = 1'b0;
   endtask

   task automatic test_back_to_back;
      int h0;
      for (int i = 0; i < 32; i++) begin
         mem[i] = {8'(2 * i + 1), 8'h01, 8'(2 * i), 8'h01};
      end
      do_reset;
      #1;
      instr_ready = 1'b1;
      step;
      step;  // cycle 2
      h0 = hs_cnt;
      for (int i = 0; i < 20; i++) begin
         vec_cnt++;
         if (instr_valid !== 1'b1) begin
            err_cnt++;
            $display("FAIL b2b_valid: got 0 in cycle %0d, required 1", i + 2);
         end
         step;
      end
      vec_cnt++;
      if (hs_cnt - h0 !== 20) begin
         err_cnt++;
         $display("FAIL b2b_rate: got %0d instructions in 20 cycles, required 20", hs_cnt - h0);
      end
      instr_ready = 1'b0;
   endtask

   task automatic test_random;
      int h0;
      for (int i = 0; i < 256; i++) mem[i] = $urandom();
      wait_lo = 0;
      wait_hi = 3;
      do_reset;
      h0 = hs_cnt;
      for (int i = 0; i < 3000; i++) begin
         step;
         instr_ready = ($urandom_range(3, 0) != 0);
         redirect    = ($urandom_range(15, 0) == 0);
         redirect_pc = $urandom_range(1023, 0);
         rst         = ($urandom_range(299, 0) == 0);
      end
      step;
      rst         = 1'b0;
      redirect    = 1'b0;
      instr_ready = 1'b0;
      vec_cnt++;
      if (hs_cnt - h0 < 300) begin
         err_cnt++;
         $display("FAIL random_progress: got %0d instructions, required at least 300", hs_cnt - h0);
      end
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst         = 1'b1;
      instr_ready = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      test_reset;
      test_two_compressed;
      test_misaligned;
      test_redirect_drop;
      test_stall;
      test_redirect_ack;
      test_redirect_handshake;
      test_back_to_back;
      test_random;
      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
